// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host block-size / block-count register:
// FSM encoding, register-image field and lane positions, bsize saturation.
package sd_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam int unsigned BSIZE_W       = 12;
  localparam int unsigned SDMA_W        = 3;
  localparam int unsigned CNT_FIELD_W   = 16;
  localparam int unsigned IMAGE_W       = 32;

  localparam int unsigned BSIZE_LSB     = 0;
  localparam int unsigned SDMA_LSB      = 12;
  localparam int unsigned CNT_LSB       = 16;

  localparam int unsigned LANE_BSIZE_LO = 0;
  localparam int unsigned LANE_BSIZE_HI = 1;
  localparam int unsigned LANE_CNT_LO   = 2;
  localparam int unsigned LANE_CNT_HI   = 3;

  localparam int unsigned BSIZE_MAX_DEF = 2048;

  function automatic logic [BSIZE_W-1:0] sat_bsize(input logic [BSIZE_W-1:0] v,
                                                   input logic [BSIZE_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sd_blkcnt.sv
// Remaining-block counter: parallel load, saturating-at-zero decrement,
// last-block flag.
module sd_blkcnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic zero;

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sd_blksize_cnt_reg.sv
// SD host Block Size / Block Count register: host writes go through a short
// IDLE->COMMIT->ACK handshake and are locked out while a transfer is running.
module sd_blksize_cnt_reg
  import sd_host_pkg::*;
#(
  parameter int unsigned BCNT_W    = 16,
  parameter int unsigned BSIZE_MAX = BSIZE_MAX_DEF,
  parameter int unsigned LANES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LANES-1:0]     wr_be,
  input  logic [8*LANES-1:0]   wr_data,
  input  logic                 rd_en,
  output logic [8*LANES-1:0]   rd_data,
  output logic                 ack,
  output logic                 busy_out,
  input  logic                 xfer_active,
  input  logic                 blk_done,
  input  logic                 blkcnt_en,
  output logic [BSIZE_W-1:0]   tranfer_bsize_out,
  output logic [SDMA_W-1:0]    host_sdmabuffb_out,
  output logic [BCNT_W-1:0]    blk_cnt_out,
  output logic                 last_blk
);

  localparam int unsigned DW = 8 * LANES;

  state_t state, state_nxt;
  logic   accept;
  logic   commit;

  logic [LANES-1:0]       cap_be;
  logic [DW-1:0]          cap_data;
  logic [3:0]             be;
  logic [IMAGE_W-1:0]     d;

  logic [BSIZE_W-1:0]     bsize, bsize_new;
  logic [SDMA_W-1:0]      sdma, sdma_new;
  logic [BCNT_W-1:0]      blk_cnt, cnt_val;
  logic [CNT_FIELD_W-1:0] cnt_mask, cnt_merged;
  logic                   cnt_load, cnt_dec;
  logic                   busy;
  logic [IMAGE_W-1:0]     image;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_en && !xfer_active) begin
          accept    = 1'b1;
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE) || xfer_active;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_be   <= '0;
      cap_data <= '0;
    end else if (accept) begin
      cap_be   <= wr_be;
      cap_data <= wr_data;
    end
  end

  assign commit = (state == ST_COMMIT);
  assign be     = 4'(cap_be);
  assign d      = IMAGE_W'(cap_data);

  // Unselected lanes keep their current value; saturation is applied to the
  // merged 12-bit size so a single-lane write cannot exceed the limit either.
  always_comb begin
    bsize_new = bsize;
    sdma_new  = sdma;
    if (be[LANE_BSIZE_LO]) bsize_new[7:0] = d[BSIZE_LSB +: 8];
    if (be[LANE_BSIZE_HI]) begin
      bsize_new[11:8] = d[BSIZE_LSB + 8 +: 4];
      sdma_new        = d[SDMA_LSB +: SDMA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bsize <= '0;
      sdma  <= '0;
    end else if (commit) begin
      bsize <= sat_bsize(bsize_new, BSIZE_W'(BSIZE_MAX));
      sdma  <= sdma_new;
    end
  end

  assign cnt_mask   = {{8{be[LANE_CNT_HI]}}, {8{be[LANE_CNT_LO]}}};
  assign cnt_merged = (d[CNT_LSB +: CNT_FIELD_W] & cnt_mask) |
                      (CNT_FIELD_W'(blk_cnt) & ~cnt_mask);
  assign cnt_val    = cnt_merged[BCNT_W-1:0];
  assign cnt_load   = commit && (be[LANE_CNT_LO] || be[LANE_CNT_HI]);
  assign cnt_dec    = blk_done && xfer_active && blkcnt_en;

  sd_blkcnt #(
    .W (BCNT_W)
  ) u_blkcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (blk_cnt),
    .last     (last_blk)
  );

  assign image   = {CNT_FIELD_W'(blk_cnt), 1'b0, sdma, bsize};
  assign rd_data = rd_en ? DW'(image) : '0;

  assign ack                = (state == ST_ACK);
  assign busy_out           = busy;
  assign tranfer_bsize_out  = bsize;
  assign host_sdmabuffb_out = sdma;
  assign blk_cnt_out        = blk_cnt;

endmodule

// File: doc/sd_blksize_cnt_reg.md
SD_BLKSIZE_CNT_REG -- requirements
Module: sd_blksize_cnt_reg

Interface
REQ-001 SHALL have parameter BCNT_W, default 16: block-count width (1..16).
REQ-002 SHALL have parameter BSIZE_MAX, default 2048: largest legal transfer block size in bytes.
REQ-003 SHALL have parameter LANES, default 4: byte lanes of the write bus (data width 8*LANES).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  write request, sampled on clk.
REQ-007 SHALL have port wr_be  input  LANES  byte-lane enables: lane0 = bits[7:0], lane1 = bits[15:8], lane2/3 = bits[31:16].
REQ-008 SHALL have port wr_data  input  8*LANES  write data.
REQ-009 SHALL have port rd_en  input  1  read strobe.
REQ-010 SHALL have port rd_data  output  8*LANES  packed register image.
REQ-011 SHALL have port ack  output  1  one-cycle write-accept pulse.
REQ-012 SHALL have port busy_out  output  1  register locked or write in progress.
REQ-013 SHALL have port xfer_active  input  1  data engine transfer in progress.
REQ-014 SHALL have port blk_done  input  1  one-cycle pulse per completed block.
REQ-015 SHALL have port blkcnt_en  input  1  Block Count Enable from the transfer mode register.
REQ-016 SHALL have port tranfer_bsize_out  output  12  transfer block size.
REQ-017 SHALL have port host_sdmabuffb_out  output  3  SDMA buffer boundary.
REQ-018 SHALL have port blk_cnt_out  output  BCNT_W  remaining block count.
REQ-019 SHALL have port last_blk  output  1  high when blk_cnt_out == 1.

Function
REQ-020 SHALL implement FSM IDLE -> COMMIT -> ACK -> IDLE.
REQ-021 IDLE -> COMMIT: wr_en=1 and xfer_active=0 sampled on the same edge; write data/enables captured there.
REQ-022 wr_en while xfer_active=1 or state != IDLE: ignored, no register change, no ack.
REQ-023 COMMIT: enabled lanes update on the edge leaving COMMIT; lane0 -> bsize[7:0]; lane1 -> bsize[11:8] = data[11:8], sdmabuffb = data[14:12], data[15] dropped; lanes2/3 -> blk_cnt = data[16+BCNT_W-1:16].
REQ-024 Stored bsize > BSIZE_MAX SHALL saturate to BSIZE_MAX; 0 is legal and stored as 0.
REQ-025 ack SHALL be high exactly during ACK: write sampled edge N, registers valid after edge N+1, ack high cycle N+2.
REQ-026 busy_out SHALL be registered, high in COMMIT and ACK and for every cycle after an edge at which xfer_active=1.
REQ-027 blk_cnt SHALL decrement by 1 on blk_done=1 with xfer_active=1, blkcnt_en=1, count != 0; at 0 it holds (no wrap).
REQ-028 blkcnt_en=0: blk_done ignored, count holds.
REQ-029 rd_data SHALL be combinational: {blk_cnt zero-extended to 16, 1'b0, sdmabuffb, bsize} when rd_en=1, else 0; unused high bits 0.
REQ-030 Decrement and COMMIT never coincide (REQ-021 lock); if xfer_active rises during COMMIT, the commit SHALL complete and ack SHALL still issue.

Reset
REQ-031 rst=0 SHALL immediately force bsize=0, sdmabuffb=0, blk_cnt=0, last_blk=0, ack=0, busy_out=0, FSM=IDLE.
REQ-032 Reset mid-write or mid-transfer SHALL abandon the operation; no ack after release.
REQ-033 First write SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-034 Package sd_host_pkg SHALL hold FSM state encoding, lane/bit-field positions, and default BSIZE_MAX.
REQ-035 Block counter SHALL be sub-module sd_blkcnt (load, decrement, zero/last flags), instantiated once.

Verification
REQ-036 Write be=4'b0011, data=32'h0000_70AF, idle -> ack 2 cycles later; bsize=12'h0AF, sdmabuffb=3'b111, blk_cnt unchanged.
REQ-037 Write be=4'b0011, data 12'hFFF in bsize -> bsize=2048 (saturated).
REQ-038 Load blk_cnt=3, xfer_active=1, blkcnt_en=1, four blk_done pulses -> 2,1(last_blk=1),0,0.
REQ-039 wr_en with xfer_active=1 -> no ack, busy_out=1, registers unchanged.
REQ-040 rst=0 during COMMIT -> all outputs 0 immediately, no ack after release.
REQ-041 blkcnt_en=0, blk_cnt=5, three blk_done -> blk_cnt stays 5.
